// File: rtl/tm_counter_pkg.sv
// Shared types and defaults for the free-running up/down test-mode counter.
package tm_counter_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  localparam int COUNT_WD_DEFAULT = 8;
  localparam int COUNT_WD_MIN     = 1;
  localparam int COUNT_WD_MAX     = 32;

endpackage

// File: rtl/tm_counter.sv
// Free-running modulo-2^COUNT_WD up/down counter with test-mode clear and direction.
// The count is observed straight from the register; nothing combinational reaches o_count.
module tm_counter
  import tm_counter_pkg::*;
#(
  parameter int COUNT_WD = COUNT_WD_DEFAULT
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_tm_reset,
  input  logic                i_tm_direction,
  output logic [COUNT_WD-1:0] o_count
);

  if (COUNT_WD < COUNT_WD_MIN || COUNT_WD > COUNT_WD_MAX) begin : g_bad_width
    $error("tm_counter: COUNT_WD must be within 1..32");
  end

  logic [COUNT_WD-1:0] r_count;
  logic [COUNT_WD-1:0] w_count_next;
  dir_e                w_dir;

  assign w_dir = dir_e'(i_tm_direction);

  // Clear beats direction; both wrap directions fall out of modulo arithmetic.
  always_comb begin
    w_count_next = r_count;
    if (i_tm_reset) begin
      w_count_next = '0;
    end else if (w_dir == DIR_DOWN) begin
      w_count_next = r_count - COUNT_WD'(1);
    end else begin
      w_count_next = r_count + COUNT_WD'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign o_count = r_count;

endmodule

// File: tb/tb_tm_counter.sv
// Directed table-driven bench for tm_counter (COUNT_WD = 8) plus async-reset sequences.
module tb_tm_counter;

  logic       clk;
  logic       rst;
  logic       tm_reset;
  logic       tm_direction;
  logic [7:0] count;

  int n_checks = 0;
  int n_bad    = 0;

  tm_counter #(.COUNT_WD(8)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_tm_reset     (tm_reset),
    .i_tm_direction (tm_direction),
    .o_count        (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       tm;
    logic       dir;
    int         edges;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %02h want %02h", name, got, want);
    end
  endtask

  // Inputs change right after a falling edge; results are sampled on a falling edge.
  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input string name, input logic tm, input logic dir,
                     input int edges, input logic [7:0] exp);
    vec_t v;
    v.name = name; v.tm = tm; v.dir = dir; v.edges = edges; v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    // Up counting and wrap, 1000 edges total from reset -> 0xE8
    add("up_5",          1'b0, 1'b0,   5, 8'h05);
    add("up_255",        1'b0, 1'b0, 250, 8'hFF);
    add("up_wrap",       1'b0, 1'b0,   1, 8'h00);
    add("up_1000",       1'b0, 1'b0, 744, 8'hE8);
    // Test clear at 0x37, then resume up
    add("clr_pre",       1'b1, 1'b0,   1, 8'h00);
    add("up_to_37",      1'b0, 1'b0,  55, 8'h37);
    add("clr_at_37",     1'b1, 1'b0,   1, 8'h00);
    add("after_clr_up",  1'b0, 1'b0,   1, 8'h01);
    // Clear wins over down, then down wrap; 1000 edges after clear -> 0x18
    add("clr_wins_down", 1'b1, 1'b1,   1, 8'h00);
    add("down_wrap",     1'b0, 1'b1,   1, 8'hFF);
    add("down_fe",       1'b0, 1'b1,   1, 8'hFE);
    add("down_1000",     1'b0, 1'b1, 998, 8'h18);
    // Direction switch at 0x10
    add("clr_sw",        1'b1, 1'b1,   1, 8'h00);
    add("up_to_10",      1'b0, 1'b0,  16, 8'h10);
    add("switch_down",   1'b0, 1'b1,   1, 8'h0F);
    add("down_0e",       1'b0, 1'b1,   1, 8'h0E);
    add("switch_up",     1'b0, 1'b0,   1, 8'h0F);
    // Held clear stays zero; first edge after release goes down to all-ones
    add("clr_held",      1'b1, 1'b0,   3, 8'h00);
    add("release_down",  1'b0, 1'b1,   1, 8'hFF);
    add("release_up",    1'b0, 1'b0,   1, 8'h00);
  end

  initial begin
    rst          = 1'b1;
    tm_reset     = 1'b0;
    tm_direction = 1'b0;
    #1;
    check("reset_async_init", count, 8'h00);
    run_edges(2);
    check("reset_held", count, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      tm_reset     = vecs[i].tm;
      tm_direction = vecs[i].dir;
      run_edges(vecs[i].edges);
      check(vecs[i].name, count, vecs[i].exp);
    end

    // Async reset from 0x5A between edges
    tm_reset = 1'b1; tm_direction = 1'b0;
    run_edges(1);
    tm_reset = 1'b0;
    run_edges(90);
    check("reach_5a", count, 8'h5A);
    #2 rst = 1'b1;
    #1 check("async_clear_5a", count, 8'h00);
    run_edges(2);
    check("async_held", count, 8'h00);
    rst = 1'b0;
    run_edges(1);
    check("after_rst_up", count, 8'h01);

    // Reset mid-operation while clear and down are active
    run_edges(3);
    check("pre_mid_rst", count, 8'h04);
    tm_reset = 1'b1; tm_direction = 1'b1;
    #2 rst = 1'b1;
    #1 check("mid_rst_clear", count, 8'h00);
    run_edges(1);
    rst = 1'b0;
    run_edges(1);
    check("mid_rst_tm_hold", count, 8'h00);
    tm_reset = 1'b0;
    run_edges(1);
    check("mid_rst_down", count, 8'hFF);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
